eth_tx_sched: RTL and testbench

- Two-requester transmit scheduler for the GMII TX path on the 125 MHz PHY clock.
- Arbitrates frame requests from two byte-stream sources, e.g. the ARP/control generator (req0) and the user payload path (req1).
- Sequences each granted frame as preamble, SFD, payload, zero pad, FCS, then inter-frame gap.
- Drives gmii_tx_en/gmii_tx_data/gmii_tx_er directly to the PHY pins. Frame content is supplied by the requesters, not hard-coded.

---
 rtl/eth_tx_pkg.sv | 49 ++++
 rtl/eth_crc32.sv | 40 ++++
 rtl/eth_tx_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_eth_tx_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared types and constants for the GMII transmit scheduler.
//   tx_state_t     - scheduler FSM states
//   ETH_*          - preamble and start-of-frame delimiter bytes
//   CRC32_*        - Ethernet CRC-32 polynomial, seed and good-frame residue
//   crc32_byte()   - one byte step of the reflected (LSB-first) CRC-32
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG,
    DROP
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Ethernet sends bits LSB first, so the register runs in the reflected domain.
  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC32_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: byte-wide Ethernet CRC-32 accumulator.
//   clock    - GMII transmit clock
//   reset    - synchronous, active-high; reloads the seed
//   init     - restart from the seed; may coincide with data_en, in which
//              case the byte is folded into a fresh seed
//   data_en  - fold data into the running CRC this cycle
//   data     - byte to fold in
//   crc_out  - registered running CRC (reflected, not inverted); the frame
//              FCS is ~crc_out sent least-significant byte first
module eth_crc32
  import eth_tx_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        data_en,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_base;
  logic [31:0] crc_next;

  always_comb begin
    crc_base = init ? CRC32_INIT : crc_q;
    crc_next = data_en ? crc32_byte(crc_base, data) : crc_base;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_next;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: two-requester GMII transmit scheduler.
//   clock              - 125 MHz GMII transmit clock
//   reset              - synchronous, active-high
//   reqN_valid/data/last/ready (N = 0,1)
//                      - byte streams, DA first, last marks final payload byte;
//                        a byte moves on valid & ready
//   gmii_tx_en/data/er - registered PHY outputs
//   busy               - FSM not in IDLE
//   grant              - requester owning the current frame (valid while busy)
//   frames_sent        - completed frames, wraps
//   aborts             - underrun / oversize aborts, wraps
//
// Output registers are loaded with the byte for the *next* cycle, so a state
// decides what the PHY sees one cycle later.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no frame; arbitrate and launch first preamble byte
//   PREAMBLE | 0x55 bytes on the wire, timer counts down to the SFD
//   SFD      | 0xD5 on the wire, ready up, first payload byte accepted
//   DATA     | payload accepted byte-per-cycle until last / abort
//   PAD      | zero bytes until the frame reaches MIN_FRAME
//   FCS      | four CRC bytes, least significant first
//   IFG      | tx_en low for IFG_BYTES cycles
//   DROP     | aborted frame, discard requester bytes until last
module eth_tx_sched
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int MAX_FRAME    = 1514,
  parameter int IFG_BYTES    = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_tx_data,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic        grant,
  output logic [15:0] frames_sent,
  output logic [15:0] aborts
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
  localparam logic [7:0]  PRE_LOAD = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LOAD = 8'(IFG_BYTES - 1);
  localparam logic [7:0]  FCS_LOAD = 8'd3;

  tx_state_t   state, state_d;
  logic [7:0]  tmr, tmr_d;
  logic [10:0] byte_cnt, byte_cnt_d, byte_cnt_inc;
  logic        grant_q, grant_d;
  logic        rr_prio, rr_prio_d;
  logic        tx_en_d, tx_er_d;
  logic [7:0]  tx_data_d;
  logic        frame_done, frame_abort;

  logic        sel_valid, sel_last;
  logic [7:0]  sel_data;
  logic        oversize, ready_int, accept;

  logic        crc_init, crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_q, fcs;
  logic [1:0]  fcs_idx;

  assign sel_valid    = grant_q ? req1_valid : req0_valid;
  assign sel_data     = grant_q ? req1_data  : req0_data;
  assign sel_last     = grant_q ? req1_last  : req0_last;
  assign byte_cnt_inc = byte_cnt + 11'd1;

  // At MAX_FRAME the next DATA cycle refuses the byte and aborts instead.
  assign oversize  = (state == DATA) && (byte_cnt == MAX_CNT);
  assign ready_int = (state == SFD) || ((state == DATA) && !oversize) || (state == DROP);
  assign accept    = ready_int && sel_valid && (state != DROP);

  assign req0_ready = ready_int && !grant_q;
  assign req1_ready = ready_int &&  grant_q;
  assign busy       = (state != IDLE);
  assign grant      = grant_q;

  // The CRC register settles on the last DATA/PAD byte exactly as FCS starts,
  // so FCS reads it directly; the timer counts 3..0, giving byte index 0..3.
  assign crc_init = (state == SFD);
  assign crc_en   = accept || (state == PAD);
  assign crc_data = (state == PAD) ? 8'h00 : sel_data;
  assign fcs      = ~crc_q;
  assign fcs_idx  = ~tmr[1:0];

  eth_crc32 u_crc (
    .clock   (clock),
    .reset   (reset),
    .init    (crc_init),
    .data_en (crc_en),
    .data    (crc_data),
    .crc_out (crc_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    tmr_d       = tmr;
    byte_cnt_d  = byte_cnt;
    grant_d     = grant_q;
    rr_prio_d   = rr_prio;
    tx_en_d     = 1'b0;
    tx_data_d   = 8'h00;
    tx_er_d     = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;

    case (state)
      IDLE: begin
        byte_cnt_d = '0;
        if (req0_valid || req1_valid) begin
          // rr_prio names the requester that wins a tie.
          grant_d   = (req0_valid && req1_valid) ? rr_prio : req1_valid;
          rr_prio_d = ~grant_d;
          tmr_d     = PRE_LOAD;
          state_d   = PREAMBLE;
          tx_en_d   = 1'b1;
          tx_data_d = ETH_PREAMBLE;
        end
      end

      PREAMBLE: begin
        tx_en_d = 1'b1;
        if (tmr == 8'd0) begin
          state_d   = SFD;
          tx_data_d = ETH_SFD;
        end else begin
          tmr_d     = tmr - 8'd1;
          tx_data_d = ETH_PREAMBLE;
        end
      end

      SFD, DATA: begin
        tx_en_d = 1'b1;
        if (sel_valid && !oversize) begin
          tx_data_d  = sel_data;
          byte_cnt_d = byte_cnt_inc;
          state_d    = DATA;
          if (sel_last) begin
            if (byte_cnt_inc < MIN_CNT) begin
              state_d = PAD;
            end else begin
              state_d = FCS;
              tmr_d   = FCS_LOAD;
            end
          end
        end else begin
          tx_er_d     = 1'b1;
          frame_abort = 1'b1;
          state_d     = DROP;
        end
      end

      PAD: begin
        tx_en_d    = 1'b1;
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_inc >= MIN_CNT) begin
          state_d = FCS;
          tmr_d   = FCS_LOAD;
        end
      end

      FCS: begin
        tx_en_d   = 1'b1;
        tx_data_d = 8'(fcs >> {fcs_idx, 3'b000});
        if (tmr == 8'd0) begin
          frame_done = 1'b1;
          state_d    = IFG;
          tmr_d      = IFG_LOAD;
        end else begin
          tmr_d = tmr - 8'd1;
        end
      end

      IFG: begin
        if (tmr == 8'd0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr - 8'd1;
        end
      end

      DROP: begin
        if (sel_valid && sel_last) begin
          state_d = IFG;
          tmr_d   = IFG_LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr          <= '0;
      byte_cnt     <= '0;
      grant_q      <= 1'b0;
      rr_prio      <= 1'b0;
      gmii_tx_en   <= 1'b0;
      gmii_tx_data <= 8'h00;
      gmii_tx_er   <= 1'b0;
      frames_sent  <= 16'd0;
      aborts       <= 16'd0;
    end else begin
      tmr          <= tmr_d;
      byte_cnt     <= byte_cnt_d;
      grant_q      <= grant_d;
      rr_prio      <= rr_prio_d;
      gmii_tx_en   <= tx_en_d;
      gmii_tx_data <= tx_data_d;
      gmii_tx_er   <= tx_er_d;
      if (frame_done) begin
        frames_sent <= frames_sent + 16'd1;
      end
      if (frame_abort) begin
        aborts <= aborts + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
module tb_eth_tx_sched;

  typedef logic [7:0] byte_q_t [$];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [7:0]  req0_data, req1_data;
  logic        gmii_tx_en, gmii_tx_er, busy, grant;
  logic [7:0]  gmii_tx_data;
  logic [15:0] frames_sent, aborts;

  int tests = 0;
  int fails = 0;

  // requester sources
  logic [7:0] mem   [2][4096];
  logic       lastf [2][4096];
  int         len[2]        = '{0, 0};
  int         idx[2]        = '{0, 0};
  int         stall_at[2]   = '{-1, -1};
  int         stall_left[2] = '{0, 0};
  logic       fire[2]       = '{1'b0, 1'b0};
  logic       vld[2]        = '{1'b0, 1'b0};
  logic       lst[2]        = '{1'b0, 1'b0};
  logic [7:0] dat[2]        = '{8'h00, 8'h00};

  assign req0_valid = vld[0];
  assign req0_data  = dat[0];
  assign req0_last  = lst[0];
  assign req1_valid = vld[1];
  assign req1_data  = dat[1];
  assign req1_last  = lst[1];

  // monitor state
  byte_q_t cap;
  int      frame_lens[$];
  int      gaps[$];
  logic    grants[$];
  int      er_cycles = 0;
  int      busy_cycles = 0;
  int      run = 0;
  int      low_run = 0;
  logic    had_frame = 1'b0;
  logic    prev_en = 1'b0;

  eth_tx_sched dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_last    (req0_last),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_last    (req1_last),
    .req1_ready   (req1_ready),
    .gmii_tx_en   (gmii_tx_en),
    .gmii_tx_data (gmii_tx_data),
    .gmii_tx_er   (gmii_tx_er),
    .busy         (busy),
    .grant        (grant),
    .frames_sent  (frames_sent),
    .aborts       (aborts)
  );

  initial begin
    forever #4 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source driver: inputs change on the falling edge; a handshake seen here
  // completes at the following rising edge.
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (fire[k]) idx[k]++;
        fire[k] = 1'b0;
        if (idx[k] < len[k] && idx[k] == stall_at[k] && stall_left[k] > 0) begin
          stall_left[k]--;
          vld[k] = 1'b0; dat[k] = 8'h00; lst[k] = 1'b0;
        end else if (idx[k] < len[k]) begin
          vld[k] = 1'b1; dat[k] = mem[k][idx[k]]; lst[k] = lastf[k][idx[k]];
        end else begin
          vld[k] = 1'b0; dat[k] = 8'h00; lst[k] = 1'b0;
        end
      end
      fire[0] = vld[0] & req0_ready;
      fire[1] = vld[1] & req1_ready;
    end
  end

  // PHY-side monitor
  initial begin
    forever begin
      @(negedge clock);
      if (gmii_tx_en) begin
        if (!prev_en) begin
          grants.push_back(grant);
          if (had_frame) gaps.push_back(low_run);
          run = 0;
        end
        cap.push_back(gmii_tx_data);
        run++;
        if (gmii_tx_er) er_cycles++;
      end else begin
        if (prev_en) begin
          frame_lens.push_back(run);
          had_frame = 1'b1;
          low_run = 0;
        end
        low_run++;
      end
      if (busy) busy_cycles++;
      prev_en = gmii_tx_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_mon();
    cap.delete();
    frame_lens.delete();
    gaps.delete();
    grants.delete();
    er_cycles = 0;
    busy_cycles = 0;
    run = 0;
    low_run = 0;
    had_frame = 1'b0;
  endtask

  task automatic clear_src();
    for (int k = 0; k < 2; k++) begin
      len[k] = 0; idx[k] = 0; stall_at[k] = -1; stall_left[k] = 0; fire[k] = 1'b0;
    end
  endtask

  task automatic add_frame(input int k, input byte_q_t q);
    foreach (q[i]) begin
      mem[k][len[k] + i]   = q[i];
      lastf[k][len[k] + i] = (i == q.size() - 1);
    end
    len[k] += q.size();
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy || idx[0] < len[0] || idx[1] < len[1]) && n < budget);
    check({tag, "_timeout"}, (n >= budget) ? 32'd1 : 32'd0, 32'd0);
    sync();
  endtask

  function automatic byte_q_t mk(input int n, input int seed);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i * seed + 3));
    return q;
  endfunction

  function automatic byte_q_t cap_q(input int off, input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back((off + i < cap.size()) ? cap[off + i] : 8'hxx);
    return q;
  endfunction

  function automatic int cmp_cap(input int off, input byte_q_t q);
    int e;
    e = 0;
    foreach (q[i]) begin
      if (off + i >= cap.size()) e++;
      else if (cap[off + i] !== q[i]) e++;
    end
    return e;
  endfunction

  function automatic logic [31:0] cap_word(input int off);
    byte_q_t q;
    q = cap_q(off, 4);
    return {q[3], q[2], q[1], q[0]};
  endfunction

  // MSB-first CRC over bit-reversed bytes (equivalent to the wire CRC-32).
  function automatic logic [31:0] crc_run(input byte_q_t q);
    logic [31:0] c;
    logic [7:0]  r;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) r[b] = q[i][7-b];
      c = c ^ {r, 24'h000000};
      for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  // FCS as a little-endian word of the four wire bytes, after padding to 60.
  function automatic logic [31:0] fcs_of(input byte_q_t q);
    byte_q_t     p;
    logic [31:0] c, w;
    p = q;
    while (p.size() < 60) p.push_back(8'h00);
    c = crc_run(p);
    for (int b = 0; b < 32; b++) w[b] = ~c[31-b];
    return w;
  endfunction

  initial begin
    byte_q_t arp, fa, fb, fc, fd, fe, ff, fg, fh, fi, fj, zeros;
    int      n, e;

    arp = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff,
            8'h00, 8'h30, 8'h1b, 8'ha0, 8'ha4, 8'h8e,
            8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h00, 8'h30, 8'h1b, 8'ha0, 8'ha4, 8'h8e, 8'h0a, 8'h00, 8'h15, 8'h0a,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0a, 8'h00, 8'h15, 8'h63};
    for (int i = 0; i < 18; i++) zeros.push_back(8'h00);

    // ---- reset state
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("rst_tx", {gmii_tx_en, gmii_tx_er, gmii_tx_data}, 32'h0);
    check("rst_status", {busy, grant, req0_ready, req1_ready}, 32'h0);
    check("rst_counters", {frames_sent, aborts}, 32'h0);

    // ---- ARP request on req0
    sync();
    clear_mon();
    add_frame(0, arp);
    wait_quiet(400, "arp");
    check("arp_len", frame_lens.size() == 1 ? frame_lens[0] : -1, 72);
    e = 0;
    for (int i = 0; i < 7; i++) if (cap[i] !== 8'h55) e++;
    if (cap[7] !== 8'hD5) e++;
    check("arp_preamble_sfd", e, 0);
    check("arp_payload", cmp_cap(8, arp), 0);
    check("arp_pad", cmp_cap(50, zeros), 0);
    check("arp_fcs", cap_word(68), fcs_of(arp));
    check("arp_residue", crc_run(cap_q(8, 64)), 32'hC704DD7B);
    check("arp_frames", frames_sent, 1);
    check("arp_busy_cycles", busy_cycles, 83);

    // ---- round robin after reset: req0, req1, req0
    reset = 1'b1;
    clear_src();
    sync(); sync();
    reset = 1'b0;
    clear_mon();
    fa = mk(60, 5); fb = mk(61, 9); fc = mk(45, 11);
    add_frame(0, fa); add_frame(0, fc); add_frame(1, fb);
    wait_quiet(800, "rr");
    check("rr_count", grants.size(), 3);
    check("rr_order", {grants[0], grants[1], grants[2]}, 3'b010);
    check("rr_lens", {frame_lens[0], frame_lens[1], frame_lens[2]}, {32'd72, 32'd73, 32'd72});
    check("rr_gap0", gaps.size() > 0 ? gaps[0] : -1, 12);
    check("rr_gap1", gaps.size() > 1 ? gaps[1] : -1, 12);
    check("rr_payload_b", cmp_cap(72 + 8, fb), 0);
    check("rr_fcs_c", cap_word(145 + 68), fcs_of(fc));
    check("rr_frames", frames_sent, 3);

    // ---- 100-byte frame on req1, no pad
    clear_mon();
    fd = mk(100, 7);
    add_frame(1, fd);
    wait_quiet(400, "big");
    check("big_len", frame_lens.size() == 1 ? frame_lens[0] : -1, 112);
    check("big_payload", cmp_cap(8, fd), 0);
    check("big_fcs", cap_word(108), fcs_of(fd));
    check("big_frames", frames_sent, 4);

    // ---- underrun after 20 bytes on req0
    clear_mon();
    fe = mk(60, 3);
    stall_at[0] = len[0] + 20;
    stall_left[0] = 3;
    add_frame(0, fe);
    wait_quiet(400, "undr");
    check("undr_len", frame_lens.size() == 1 ? frame_lens[0] : -1, 29);
    check("undr_er_cycles", er_cycles, 1);
    check("undr_er_byte", cap.size() > 28 ? cap[28] : 8'hxx, 8'h00);
    check("undr_aborts", aborts, 1);
    check("undr_frames", frames_sent, 4);
    check("undr_drained", len[0] - idx[0], 0);

    // ---- oversize on req0, then a normal frame on req1
    clear_mon();
    ff = mk(1600, 13);
    add_frame(0, ff);
    repeat (20) sync();
    fg = mk(60, 17);
    add_frame(1, fg);
    wait_quiet(4000, "ovr");
    check("ovr_nframes", frame_lens.size(), 2);
    check("ovr_len", frame_lens[0], 8 + 1514 + 1);
    check("ovr_er_cycles", er_cycles, 1);
    check("ovr_aborts", aborts, 2);
    check("ovr_next_grant", grants.size() == 2 ? {grants[0], grants[1]} : 2'bxx, 2'b01);
    check("ovr_next_len", frame_lens[1], 72);
    check("ovr_next_fcs", cap_word(1523 + 68), fcs_of(fg));
    check("ovr_frames", frames_sent, 5);

    // ---- reset in the middle of a req0 frame
    clear_mon();
    fh = mk(100, 21);
    add_frame(0, fh);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!gmii_tx_en && n < 20);
    check("mid_start_timeout", (n >= 20) ? 32'd1 : 32'd0, 32'd0);
    repeat (29) @(negedge clock);
    check("mid_pre_en", gmii_tx_en, 1'b1);
    @(posedge clock);
    #2 reset = 1'b1;
    clear_src();
    @(posedge clock);
    @(negedge clock);
    check("mid_tx_off", {gmii_tx_en, gmii_tx_er, gmii_tx_data}, 32'h0);
    check("mid_counters", {frames_sent, aborts}, 32'h0);
    check("mid_status", {busy, grant}, 2'b00);
    sync();
    reset = 1'b0;
    clear_mon();
    fi = mk(60, 19); fj = mk(60, 23);
    add_frame(0, fi); add_frame(1, fj);
    wait_quiet(600, "post");
    check("post_order", grants.size() == 2 ? {grants[0], grants[1]} : 2'bxx, 2'b01);
    check("post_frames", frames_sent, 2);
    check("post_fcs_i", cap_word(68), fcs_of(fi));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
